// File: rtl/call_ret_pkg.sv
`default_nettype none
// ============================================================================
// Module      : call_ret_pkg
// Description : Shared states and constants for the CALL/RET sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package call_ret_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DEPTH  = 255;
    localparam int RET_INC    = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH     = 3'd1,
        ST_POP      = 3'd2,
        ST_POP_WAIT = 3'd3,
        ST_LOAD     = 3'd4,
        ST_ERR      = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/stack_occ_counter.sv
`default_nettype none
// ============================================================================
// Module      : stack_occ_counter
// Description : Saturating occupancy counter for the return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_occ_counter
    import call_ret_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] c_max = CNT_W'(DEPTH);

    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;

    assign w_full  = (r_count == c_max);
    assign w_empty = (r_count == '0);

    // Saturates at both ends so the count can never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (inc && !dec && !w_full) begin
            r_count <= r_count + 1'b1;
        end else if (dec && !inc && !w_empty) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/call_ret_seq.sv
`default_nettype none
// ============================================================================
// Module      : call_ret_seq
// Description : CALL/RET sequencer driving an external return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
module call_ret_seq
    import call_ret_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              call_req,
    input  logic              ret_req,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] target_addr,
    output logic              busy,
    output logic              done,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_out,
    output logic              err_overflow,
    output logic              err_underflow,
    output logic              stk_enable,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [ADDR_W-1:0] stk_wdata,
    input  logic [ADDR_W-1:0] stk_rdata,
    input  logic              stk_empty
);

    localparam int               c_cnt_w    = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_occ_full = c_cnt_w'(DEPTH);

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_pc_load;
    logic [ADDR_W-1:0]   r_pc_out;
    logic                r_err_ovf;
    logic                r_err_unf;
    logic                r_stk_en;
    logic                r_stk_push;
    logic                r_stk_pop;
    logic [ADDR_W-1:0]   r_ret_addr;
    logic [ADDR_W-1:0]   r_target;

    logic [c_cnt_w-1:0]  w_occ;
    logic                w_full;
    logic                w_empty;
    logic                w_inc;
    logic                w_dec;

    assign w_inc = (r_state == ST_PUSH) && !w_full;
    assign w_dec = (r_state == ST_POP)  && !w_empty;

    stack_occ_counter #(
        .DEPTH (DEPTH),
        .CNT_W (c_cnt_w)
    ) u_occ (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc),
        .dec   (w_dec),
        .count (w_occ),
        .full  (w_full),
        .empty (w_empty)
    );

    // All outputs are registered alongside the state, so each output pulse
    // lines up with the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pc_load  <= 1'b0;
            r_pc_out   <= '0;
            r_err_ovf  <= 1'b0;
            r_err_unf  <= 1'b0;
            r_stk_en   <= 1'b0;
            r_stk_push <= 1'b0;
            r_stk_pop  <= 1'b0;
            r_ret_addr <= '0;
            r_target   <= '0;
        end else begin
            r_done     <= 1'b0;
            r_pc_load  <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_err_unf  <= 1'b0;
            r_stk_en   <= 1'b0;
            r_stk_push <= 1'b0;
            r_stk_pop  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (call_req) begin
                        r_ret_addr <= pc_in + ADDR_W'(RET_INC);
                        r_target   <= target_addr;
                        r_busy     <= 1'b1;
                        if (w_occ == c_occ_full) begin
                            r_state   <= ST_ERR;
                            r_err_ovf <= 1'b1;
                        end else begin
                            r_state    <= ST_PUSH;
                            r_stk_en   <= 1'b1;
                            r_stk_push <= 1'b1;
                        end
                    end else if (ret_req) begin
                        r_busy <= 1'b1;
                        if (w_occ == '0 || stk_empty) begin
                            r_state   <= ST_ERR;
                            r_err_unf <= 1'b1;
                        end else begin
                            r_state   <= ST_POP;
                            r_stk_en  <= 1'b1;
                            r_stk_pop <= 1'b1;
                        end
                    end
                end
                ST_PUSH: begin
                    r_state   <= ST_LOAD;
                    r_pc_out  <= r_target;
                    r_done    <= 1'b1;
                    r_pc_load <= 1'b1;
                end
                ST_POP: begin
                    r_state <= ST_POP_WAIT;
                end
                ST_POP_WAIT: begin
                    r_state   <= ST_LOAD;
                    r_pc_out  <= stk_rdata;
                    r_done    <= 1'b1;
                    r_pc_load <= 1'b1;
                end
                ST_LOAD, ST_ERR: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign pc_load       = r_pc_load;
    assign pc_out        = r_pc_out;
    assign err_overflow  = r_err_ovf;
    assign err_underflow = r_err_unf;
    assign stk_enable    = r_stk_en;
    assign stk_push      = r_stk_push;
    assign stk_pop       = r_stk_pop;
    assign stk_wdata     = r_ret_addr;

endmodule
`default_nettype wire

// File: tb/tb_call_ret_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_call_ret_seq
// Description : Self-checking bench for call_ret_seq with a stack emulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_call_ret_seq;

    localparam int DEPTH = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        call_req = 1'b0, ret_req = 1'b0, force_empty = 1'b0;
    logic [31:0] pc_in = '0, target_addr = '0;
    logic        busy, done, pc_load, err_overflow, err_underflow;
    logic        stk_enable, stk_push, stk_pop, stk_empty;
    logic [31:0] pc_out, stk_wdata, stk_rdata;

    logic        call2 = 1'b0;
    logic [31:0] pc2 = '0, tgt2 = '0;
    logic        busy2, done2, pc_load2, ovf2, unf2, en2, push2, pop2;
    logic [31:0] pc_out2, wdata2;
    int          push_cnt2 = 0;

    int total = 0;
    int bad   = 0;

    logic [31:0] stk_q[$];
    logic [31:0] mdl_q[$];
    logic [31:0] mdl_pc = '0;

    always #5 clk = ~clk;

    call_ret_seq #(.ADDR_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req),
        .pc_in(pc_in), .target_addr(target_addr), .busy(busy), .done(done),
        .pc_load(pc_load), .pc_out(pc_out), .err_overflow(err_overflow),
        .err_underflow(err_underflow), .stk_enable(stk_enable),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
        .stk_rdata(stk_rdata), .stk_empty(stk_empty)
    );

    call_ret_seq #(.ADDR_W(32), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .call_req(call2), .ret_req(1'b0),
        .pc_in(pc2), .target_addr(tgt2), .busy(busy2), .done(done2),
        .pc_load(pc_load2), .pc_out(pc_out2), .err_overflow(ovf2),
        .err_underflow(unf2), .stk_enable(en2), .stk_push(push2),
        .stk_pop(pop2), .stk_wdata(wdata2), .stk_rdata(32'h0),
        .stk_empty(push_cnt2 == 0)
    );

    // External stack: pop data appears the cycle after the pop strobe.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stk_q.delete();
            stk_rdata <= '0;
        end else begin
            if (stk_push) stk_q.push_back(stk_wdata);
            if (stk_pop && stk_q.size() > 0) stk_rdata <= stk_q.pop_back();
        end
    end
    assign stk_empty = force_empty || (stk_q.size() == 0);

    always @(posedge clk) if (push2) push_cnt2 <= push_cnt2 + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {busy, done, pc_load, err_overflow, err_underflow, stk_enable, stk_push, stk_pop};
    endfunction

    // One operation; expectations come from the abstract stack model and the
    // documented cycle timeline. Garbage requests are driven while busy.
    task automatic run_op(input logic c, input logic r, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic fe, output logic err_seen);
        int          kind;
        int          len;
        logic [31:0] old_pc = mdl_pc;
        logic [31:0] new_pc = mdl_pc;
        logic [31:0] ra = pc + 32'd4;
        logic [7:0]  exp_v;
        if (c) begin
            if (mdl_q.size() == DEPTH) kind = 2;
            else begin kind = 0; mdl_q.push_back(ra); new_pc = tgt; end
        end else if (mdl_q.size() == 0 || fe) begin
            kind = 3;
        end else begin
            kind = 1;
            new_pc = mdl_q.pop_back();
        end
        len = (kind == 0) ? 2 : (kind == 1) ? 3 : 1;
        call_req = c; ret_req = r; pc_in = pc; target_addr = tgt; force_empty = fe;
        err_seen = 1'b0;
        for (int k = 1; k <= len + 1; k++) begin
            @(posedge clk); #1;
            exp_v = {k <= len,
                     kind <= 1 && k == len, kind <= 1 && k == len,
                     kind == 2 && k == 1, kind == 3 && k == 1,
                     kind <= 1 && k == 1, kind == 0 && k == 1, kind == 1 && k == 1};
            chk($sformatf("outs[k=%0d,kind=%0d]", k, kind), 64'(outs()), 64'(exp_v));
            chk($sformatf("pc_out[k=%0d]", k), 64'(pc_out),
                64'((kind <= 1 && k >= len) ? new_pc : old_pc));
            if (kind == 0 && k == 1) chk("stk_wdata", 64'(stk_wdata), 64'(ra));
            if (err_overflow || err_underflow) err_seen = 1'b1;
            if (k <= len) begin
                call_req = 1'($urandom); ret_req = 1'($urandom);
                pc_in = $urandom; target_addr = $urandom;
            end else begin
                call_req = 1'b0; ret_req = 1'b0; force_empty = 1'b0;
            end
        end
        mdl_pc = new_pc;
    endtask

    typedef struct {
        logic        c;
        logic        r;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        fe;
        logic [31:0] exp_pc;
        logic        exp_err;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e;
        tbl[0] = '{1'b1, 1'b0, 32'h100,      32'h2000, 1'b0, 32'h2000, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 32'h0,        32'h0,    1'b0, 32'h104,  1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'h0,        32'h0,    1'b0, 32'h104,  1'b1};
        tbl[3] = '{1'b1, 1'b1, 32'hFFFFFFFC, 32'h3000, 1'b0, 32'h3000, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 32'h0,        32'h0,    1'b0, 32'h0,    1'b0};
        tbl[5] = '{1'b1, 1'b0, 32'h40,       32'h500,  1'b0, 32'h500,  1'b0};
        tbl[6] = '{1'b0, 1'b1, 32'h0,        32'h0,    1'b1, 32'h500,  1'b1};
        tbl[7] = '{1'b0, 1'b1, 32'h0,        32'h0,    1'b0, 32'h44,   1'b0};

        // Reset state
        #1;
        chk("reset_outs", 64'(outs()), 64'h0);
        chk("reset_pc", 64'(pc_out), 64'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_outs", 64'(outs()), 64'h0);

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].c, tbl[i].r, tbl[i].pc, tbl[i].tgt, tbl[i].fe, e);
            chk($sformatf("tbl%0d_pc", i), 64'(pc_out), 64'(tbl[i].exp_pc));
            chk($sformatf("tbl%0d_err", i), 64'(e), 64'(tbl[i].exp_err));
        end

        // DEPTH=2 instance: third CALL overflows, only two pushes
        for (int n = 0; n < 3; n++) begin
            logic ovf_seen = 1'b0;
            call2 = 1'b1; pc2 = 32'h1000 * (n + 1); tgt2 = 32'hA0 + 32'(n);
            @(posedge clk); #1;
            call2 = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (ovf2) ovf_seen = 1'b1;
                @(posedge clk); #1;
            end
            chk($sformatf("d2_ovf%0d", n), 64'(ovf_seen), 64'(n == 2));
        end
        chk("d2_push_cnt", 64'(push_cnt2), 64'd2);
        chk("d2_pc_out", 64'(pc_out2), 64'hA1);

        // Randomized operations against the abstract model
        for (int i = 0; i < 60; i++) begin
            int sel = $urandom_range(0, 9);
            logic fe = ($urandom_range(0, 9) == 0);
            run_op(sel < 5, sel >= 4, $urandom, $urandom, fe, e);
        end

        // Reset during POP_WAIT
        run_op(1'b1, 1'b0, 32'h700, 32'h9000, 1'b0, e);
        ret_req = 1'b1;
        @(posedge clk); #1;
        ret_req = 1'b0;
        chk("rst_pre_pop", 64'(stk_pop), 64'd1);
        @(posedge clk); #1;
        chk("rst_pre_wait_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("rst_async_outs", 64'(outs()), 64'h0);
        chk("rst_async_pc", 64'(pc_out), 64'h0);
        mdl_q.delete();
        mdl_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        begin
            logic stray = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #1;
                if (done || pc_load || busy) stray = 1'b1;
            end
            chk("rst_no_stray_load", 64'(stray), 64'd0);
        end
        run_op(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, e);
        chk("rst_occ_cleared", 64'(e), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/call_ret_seq.md
CALL_RET_SEQ -- requirements
Module: call_ret_seq

Interface
REQ-001 Parameter ADDR_W, 32, width of PC, return address and stack data.
REQ-002 Parameter DEPTH, 255, maximum number of stacked return addresses.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 call_req  in  1  level request to perform CALL; sampled only in IDLE.
REQ-006 ret_req  in  1  level request to perform RET; sampled only in IDLE.
REQ-007 pc_in  in  ADDR_W  current PC; sampled with call_req.
REQ-008 target_addr  in  ADDR_W  CALL destination; sampled with call_req.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle pulse when an operation completes successfully.
REQ-011 pc_load  out  1  one-cycle pulse, coincident with done; pc_out valid.
REQ-012 pc_out  out  ADDR_W  new PC; holds its value until the next pc_load.
REQ-013 err_overflow / err_underflow  out  1 each  one-cycle error pulses.
REQ-014 stk_enable  out  1  high while a stack strobe is driven.
REQ-015 stk_push / stk_pop  out  1 each  one-cycle stack strobes; never both high.
REQ-016 stk_wdata  out  ADDR_W  data presented to the stack during stk_push.
REQ-017 stk_rdata  in  ADDR_W  stack pop data, valid one cycle after stk_pop.
REQ-018 stk_empty  in  1  stack empty flag.

Function
REQ-019 FSM states: IDLE, PUSH, POP, POP_WAIT, LOAD, ERR.
REQ-020 IDLE: call_req=1 -> ERR if occ==DEPTH, else PUSH; latch pc_in+4 and target_addr.
REQ-021 IDLE: ret_req=1 with call_req=0 -> ERR if occ==0 or stk_empty=1, else POP.
REQ-022 When call_req and ret_req are both high in IDLE, CALL wins; RET is dropped and must be re-requested.
REQ-023 Return address = pc_in + 4, truncated to ADDR_W bits (wraps 0xFFFFFFFC -> 0x00000000).
REQ-024 PUSH (1 cycle): stk_enable=1, stk_push=1, stk_wdata=latched return address, occ+1; next state LOAD, with pc_out <= target.
REQ-025 POP (1 cycle): stk_enable=1, stk_pop=1, occ-1; next state POP_WAIT.
REQ-026 POP_WAIT (1 cycle): capture stk_rdata into pc_out; next state LOAD.
REQ-027 LOAD (1 cycle): done=1, pc_load=1; next state IDLE.
REQ-028 ERR (1 cycle): err_overflow (CALL) or err_underflow (RET) pulses; no stack strobe, no pc_load, occ unchanged; next state IDLE.
REQ-029 Latency from request sampled in IDLE at edge N: CALL done at N+2, RET done at N+3, error pulse at N+1.
REQ-030 Requests are ignored while busy=1; back-to-back operations need at least one IDLE cycle.
REQ-031 occ is a counter of width clog2(DEPTH+1); it never wraps; inc/dec occur only in PUSH/POP.

Reset
REQ-032 While rst=0: state=IDLE, occ=0, pc_out=0, and all strobes, busy, done, pc_load and error outputs are 0, immediately and asynchronously.
REQ-033 Reset asserted mid-operation abandons the operation; no partial pc_load is issued after release.

Structure
REQ-034 A shared package call_ret_pkg SHALL hold the state enumeration, RET_INC=4 and the default ADDR_W/DEPTH constants.
REQ-035 The occupancy counter SHALL be a sub-module, stack_occ_counter (inc, dec, count, full, empty).

Verification
REQ-036 Reset, then CALL with pc_in=0x100, target=0x2000 -> stk_push with wdata 0x104 at N+1; pc_out=0x2000 with done at N+2.
REQ-037 After REQ-036, RET -> stk_pop at N+1; stack returns 0x104; pc_out=0x104 with done at N+3; occ=0.
REQ-038 RET with empty stack -> err_underflow pulse at N+1; no stk_pop; pc_out unchanged.
REQ-039 DEPTH=2: three CALLs -> third raises err_overflow; only two stk_push pulses are seen.
REQ-040 call_req and ret_req both high -> only the CALL sequence occurs; pc_in=0xFFFFFFFC pushes 0x00000000.
REQ-041 rst=0 during POP_WAIT -> all outputs 0 at once; no done or pc_load after release.
